// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch stage: issues imem requests, presents instr/pc/pc_inc
// to decode, and handles redirect squash, stall hold through a one-entry skid buffer, and halt.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [15:0] next_pc,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] pc_inc,
    output logic        instr_valid,
    output logic        halted
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam logic [AW-1:0] STEP = AW'(PC_STEP);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          to_halt_q, to_halt_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] redirect_pc_q, redirect_pc_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_inc_q, pc_inc_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;
    logic [DW-1:0] skid_instr_q, skid_instr_d;
    logic [AW-1:0] skid_pc_q, skid_pc_d;
    logic          skid_valid_q, skid_valid_d;
    logic [AW-1:0] drain_pc;
    logic          drain_halt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            to_halt_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= '0;
            instr_q       <= '0;
            pc_q          <= '0;
            pc_inc_q      <= '0;
            valid_q       <= 1'b0;
            halted_q      <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_halt_q     <= to_halt_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            pc_inc_q      <= pc_inc_d;
            valid_q       <= valid_d;
            halted_q      <= halted_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

    // Next-state and output logic; priority redirect > halt > stall > normal
    always_comb begin
        state_d       = state_q;
        to_halt_d     = to_halt_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        pc_inc_d      = pc_inc_q;
        valid_d       = valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        skid_valid_d  = skid_valid_q;
        drain_pc      = redirect ? next_pc : redirect_pc_q;
        drain_halt    = redirect ? 1'b0 : to_halt_q;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    if (imem_ready) begin
                        fetch_pc_d = next_pc;
                    end else begin
                        redirect_pc_d = next_pc;
                        to_halt_d     = 1'b0;
                        state_d       = S_DRAIN;
                    end
                end else if (halt && valid_q) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    if (imem_ready) begin
                        state_d = S_HALTED;
                    end else begin
                        to_halt_d = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end else if (imem_ready) begin
                    fetch_pc_d = fetch_pc_q + STEP;
                    if (!(stall && valid_q)) begin
                        instr_d  = imem_rdata;
                        pc_d     = fetch_pc_q;
                        pc_inc_d = fetch_pc_q + STEP;
                        valid_d  = 1'b1;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = fetch_pc_q;
                        skid_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // fetch_pc_q still holds the outstanding address; the response is dropped
                valid_d      = 1'b0;
                skid_valid_d = 1'b0;
                if (redirect) begin
                    redirect_pc_d = next_pc;
                    to_halt_d     = 1'b0;
                end
                if (imem_ready) begin
                    to_halt_d = 1'b0;
                    if (drain_halt) begin
                        state_d = S_HALTED;
                    end else begin
                        fetch_pc_d = drain_pc;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    fetch_pc_d   = next_pc;
                    state_d      = S_FETCH;
                end else if (halt && valid_q) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    state_d      = S_HALTED;
                end else if (!stall) begin
                    instr_d      = skid_instr_q;
                    pc_d         = skid_pc_q;
                    pc_inc_d     = skid_pc_q + STEP;
                    valid_d      = skid_valid_q;
                    skid_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase

        halted_d = (state_d == S_HALTED);
    end

    // Request is a decode of the state register, forced low while reset is held
    assign imem_req    = rst_n && ((state_q == S_FETCH) || (state_q == S_DRAIN));
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_inc      = pc_inc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- PC register and instruction-fetch stage. It consumes the redirect target from the next-PC selector and issues fetch requests to instruction memory over a ready handshake.
- Presents the fetched instr, its pc and its pc_inc (pc+2) to decode.
- Owns squash on redirect, stall hold with a one-entry skid buffer, and halt.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset.
- PC_STEP, 2, byte increment per instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect  in  1  taken branch/jump/RET/RTI resolved this cycle.
- next_pc  in  16  redirect target, sampled only when redirect=1.
- stall  in  1  decode cannot accept; hold outputs.
- halt  in  1  HALT decoded from the currently presented instr.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address.
- imem_ready  in  1  memory completes request this cycle; imem_rdata valid.
- imem_rdata  in  16  fetched instruction word.
- instr  out  16  instruction to decode.
- pc  out  16  address of instr.
- pc_inc  out  16  pc + PC_STEP, modulo 2^16.
- instr_valid  out  1  instr/pc/pc_inc meaningful.
- halted  out  1  fetch permanently stopped.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - fetch_pc=RESET_PC; state=FETCH.
  - instr=0, pc=0, pc_inc=0, instr_valid=0, halted=0, skid empty.
  - imem_req=0 while rst_n=0.
- States: FETCH, DRAIN, HOLD, HALTED. DRAIN carries a to_halt flag.
- Request rule:
  - imem_req=1 in FETCH and DRAIN, 0 otherwise.
  - imem_addr=fetch_pc in FETCH and the latched old address in DRAIN.
  - imem_addr must stay stable while imem_req=1 and imem_ready=0.
- Priority per cycle: redirect > halt > stall > normal.
- FETCH, response (imem_ready=1), no redirect/halt:
  - If !(stall & instr_valid): outputs <= {rdata, fetch_pc, fetch_pc+2}, instr_valid<=1, fetch_pc<=fetch_pc+2, stay FETCH.
  - Else: response goes to skid, fetch_pc<=fetch_pc+2, go HOLD.
  - Response latency is 1 cycle minimum (ready in the cycle of req). Back-to-back responses give one instr per cycle.
- FETCH, no response:
  - Outputs hold.
  - If stall=0, instr_valid<=0 (the consumed bubble is not re-presented).
- HOLD:
  - imem_req=0.
  - When stall=0: skid moves to outputs, instr_valid=1, skid empties, go FETCH.
- redirect=1 (any state except HALTED):
  - instr_valid<=0 and skid emptied in the same edge.
  - If FETCH with imem_ready=1 or in HOLD: fetch_pc<=next_pc, go FETCH.
  - If FETCH with imem_ready=0: latch next_pc into redirect_pc, go DRAIN (to_halt=0).
- DRAIN:
  - Keep the old request until imem_ready=1 and discard that data.
  - Then fetch_pc<=redirect_pc and go FETCH, or go HALTED if to_halt.
  - A redirect arriving during DRAIN overwrites redirect_pc and clears to_halt.
- halt=1 with instr_valid=1, no redirect:
  - instr_valid<=0, skid cleared.
  - Outstanding unanswered request: go DRAIN with to_halt=1.
  - Otherwise: go HALTED.
  - halt with instr_valid=0 is ignored.
- HALTED:
  - halted=1, imem_req=0, outputs frozen, instr_valid=0.
  - redirect, stall and halt are ignored; exit only by reset.
- Wrap: fetch_pc 16'hFFFE advances to 16'h0000 with no flag.
- Reset asserted mid-DRAIN/HOLD: immediate return to reset values; the in-flight memory response is the memory's problem (imem_req drops).

Test Plan:
- Sequential fetch, imem_ready tied 1, RESET_PC=0, rdata=addr^16'hA5A5 -> instr_valid from cycle 1; pc 0,2,4,6; pc_inc 2,4,6,8; instr 16'hA5A5,16'hA5A7,...
- Wait states: ready asserted every 3rd cycle -> imem_addr stable across waits, instr_valid pulses once per response, no pc skipped.
- Stall: stall=1 for 3 cycles with instr_valid=1 and a response arriving -> outputs frozen, HOLD entered, imem_req=0. After release, skid instr presented next cycle, then fetch resumes at the following address.
- Redirect during wait: redirect=1, next_pc=16'h0040 while request to 16'h0010 is outstanding -> instr_valid=0 next cycle, imem_addr stays 16'h0010 until ready, data discarded, next request at 16'h0040.
- Redirect vs halt same cycle: redirect=1 (next_pc=16'h0100), halt=1 -> no halt, fetch at 16'h0100. Later halt alone -> halted=1, imem_req=0 permanently until rst_n pulse restores pc fetch at RESET_PC.
- Wrap: start fetch_pc=16'hFFFC with ready=1 -> pc FFFC, FFFE, 0000; pc_inc for FFFE is 16'h0000.
